// File: rtl/mau_acc_alu.sv
// rtl/mau_acc_alu.sv - MAU arithmetic core: 2-stage pipeline, saturating accumulator, FWFT result queue
module mau_acc_alu #(
    parameter int W         = 8,
    parameter int QF        = 4,
    parameter int ACC_GUARD = 4,
    parameter int DEPTH     = 4,
    localparam int RW       = 2 * W + 2,
    localparam int AW       = RW + ACC_GUARD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [7:0]           op,
    input  logic signed [W-1:0]  x0,
    input  logic signed [W-1:0]  x1,
    input  logic signed [W-1:0]  y0,
    input  logic signed [W-1:0]  y1,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic signed [AW-1:0] res_q,
    output logic                 res_ovf,
    output logic                 res_err,
    output logic signed [AW-1:0] acc_q,
    output logic                 busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    logic unused_op7;
    assign unused_op7 = op[7];

    // Stage 1: every opcode reduces to the sum of two exact RW-bit terms.
    logic signed [RW-1:0] ex0, ex1, ey0, ey1, dx, dy, term_a, term_b;
    logic                 illegal;

    assign ex0 = RW'(x0);
    assign ex1 = RW'(x1);
    assign ey0 = RW'(y0);
    assign ey1 = RW'(y1);
    assign dx  = ex0 - ex1;
    assign dy  = ey0 - ey1;

    always_comb begin
        term_a  = '0;
        term_b  = '0;
        illegal = 1'b0;
        case (op[3:0])
            4'd0: begin term_a = ex0;       term_b = ex1;          end
            4'd1: begin term_a = ex0;       term_b = -ex1;         end
            4'd2: begin term_a = ex0 * ex1;                        end
            4'd3: begin term_a = ex0 * ex1; term_b = ey0 * ey1;    end
            4'd4: begin term_a = ex0 * ey1; term_b = -(ex1 * ey0); end
            4'd5: begin term_a = dx * dx;   term_b = dy * dy;      end
            4'd6: begin term_a = ex0 * ex1; term_b = ey0;          end
            default: illegal = 1'b1;
        endcase
    end

    logic                 live;
    logic                 cmd_fire;
    logic                 s1_valid, s1_acc_en, s1_q_en, s1_clr, s1_err;
    logic signed [RW-1:0] s1_a, s1_b;

    assign cmd_fire = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live      <= 1'b0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_acc_en <= 1'b0;
            s1_q_en   <= 1'b0;
            s1_clr    <= 1'b0;
            s1_err    <= 1'b0;
        end else begin
            live     <= 1'b1;
            s1_valid <= cmd_fire;
            if (cmd_fire) begin
                s1_a      <= term_a;
                s1_b      <= term_b;
                s1_acc_en <= op[4];
                s1_q_en   <= op[5];
                s1_clr    <= op[6];
                s1_err    <= illegal;
            end
        end
    end

    // Stage 2 reads acc_q directly; the accumulator is only written here, so
    // a following command in S2 always sees the previous update.
    logic signed [RW-1:0] raw, scaled;
    logic signed [AW-1:0] s_ext, base, sat_sum, wr_q;
    logic signed [AW:0]   sum_w;
    logic                 do_acc, do_clr, ovf, wr_ovf;

    assign raw     = s1_a + s1_b;
    assign scaled  = s1_q_en ? (raw >>> QF) : raw;
    assign s_ext   = AW'(scaled);
    assign do_acc  = s1_acc_en && !s1_err;
    assign do_clr  = s1_clr && !s1_err;
    assign base    = do_clr ? '0 : acc_q;
    assign sum_w   = (AW+1)'(base) + (AW+1)'(s_ext);
    assign ovf     = sum_w[AW] != sum_w[AW-1];
    assign sat_sum = ovf ? (sum_w[AW] ? ACC_MIN : ACC_MAX) : sum_w[AW-1:0];
    assign wr_q    = do_acc ? sat_sum : s_ext;
    assign wr_ovf  = do_acc && ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (s1_valid) begin
            if (do_acc)
                acc_q <= sat_sum;
            else if (do_clr)
                acc_q <= '0;
        end
    end

    logic signed [AW-1:0] mem_q   [DEPTH];
    logic                 mem_ovf [DEPTH];
    logic                 mem_err [DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic [CW:0]          occ;
    logic                 push, pop;

    assign push      = s1_valid;
    assign res_valid = (count != '0);
    assign pop       = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr]   <= wr_q;
            mem_ovf[wr_ptr] <= wr_ovf;
            mem_err[wr_ptr] <= s1_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign res_q   = res_valid ? mem_q[rd_ptr]   : '0;
    assign res_ovf = res_valid ? mem_ovf[rd_ptr] : 1'b0;
    assign res_err = res_valid ? mem_err[rd_ptr] : 1'b0;

    // Reserve a FIFO slot for whatever is in S1; no credit taken from a same-cycle pop.
    assign occ       = {1'b0, count} + {{CW{1'b0}}, s1_valid};
    assign cmd_ready = live && (occ < (CW+1)'(DEPTH));
    assign busy      = s1_valid || res_valid;
endmodule
